// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU sharing controller: op codes, FSM state type
// and the op-code legality check.
package alu_share_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_LUI = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    // 100 and 101 are the only unassigned encodings.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op != 3'b100) && (op != 3'b101);
    endfunction

endpackage

// File: rtl/alu_share_alu.sv
// Shared single-cycle 32-bit ALU datapath (purely combinational).
// Ports: op_i op code, a_i/b_i operands, result_o result, err_o undefined op.
module alu_share_alu
    import alu_share_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        err_o
);

    always_comb begin
        result_o = '0;
        err_o    = ~op_is_valid(op_i);
        case (op_i)
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_ADD:  result_o = a_i + b_i;
            OP_SUB:  result_o = a_i - b_i;
            OP_LUI:  result_o = {b_i[15:0], 16'h0000};
            OP_SLT:  result_o = {31'd0, (a_i < b_i)};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Searches req_i starting one past
// last_grant_i with wrap-around; the pointer register lives in the parent.
// Ports: req_i request vector, last_grant_i previous winner, enable_i gates all
// grants, grant_o one-hot winner, grant_idx_o winner index.
module rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_grant_i,
    input  logic          enable_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    always_comb begin
        int  idx;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 1; k <= int'(N); k++) begin
            idx = (int'(last_grant_i) + k) % int'(N);
            if (enable_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one ALU between NUM_REQ requesters.
// Ports: clk/rst_n clock and async active-low reset; req_valid/req_ready
// per-requester handshake with packed req_a/req_b/req_op operands; rsp_valid/
// rsp_ready response handshake carrying rsp_id, rsp_result and rsp_err.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    input  logic [NUM_REQ*3-1:0]  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [DW-1:0]         rsp_result,
    output logic                  rsp_err
);

    state_e            state_q;
    logic [ID_W-1:0]   last_grant_q;
    logic [DW-1:0]     a_q, b_q;
    logic [2:0]        op_q;
    logic [ID_W-1:0]   id_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [DW-1:0]      sel_a, sel_b;
    logic [2:0]         sel_op;
    logic [DW-1:0]      alu_result;
    logic               alu_err;
    logic               arb_en;

    // rst_n gates the arbiter so req_ready reads 0 while reset is held.
    assign arb_en    = (state_q == StIdle) && rst_n;
    assign req_ready = grant;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (arb_en),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i*DW +: DW];
                sel_b  = req_b[i*DW +: DW];
                sel_op = req_op[i*3 +: 3];
            end
        end
    end

    alu_share_alu u_alu (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .err_o    (alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_err      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // A grant implies the matching valid, so any grant is a transfer.
                    if (|grant) begin
                        a_q          <= sel_a;
                        b_q          <= sel_b;
                        op_q         <= sel_op;
                        id_q         <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    rsp_result <= alu_result;
                    rsp_err    <= alu_err;
                    rsp_id     <= id_q;
                    rsp_valid  <= 1'b1;
                    state_q    <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    localparam int unsigned N  = 3;
    localparam int unsigned IW = 2;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N*3-1:0]  req_op = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_result;
    logic            rsp_err;

    alu_share_ctrl #(
        .NUM_REQ (N),
        .ID_W    (IW),
        .DW      (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int model_last = N - 1;

    logic [31:0] opa [N];
    logic [31:0] opb [N];
    logic [2:0]  opc [N];

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        err;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural ALU: the op-code table as arithmetic.
    task automatic ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic err);
        err = 1'b0;
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd2: res = a + b;
            3'd6: res = a - b;
            3'd3: res = b << 16;
            3'd7: res = (a < b) ? 32'd1 : 32'd0;
            default: begin res = 32'd0; err = 1'b1; end
        endcase
    endtask

    // Round-robin rule: first requester after the last winner, wrapping.
    function automatic int pick(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= int'(N); k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < int'(N); i++) begin
            req_a[i*DW +: DW] = opa[i];
            req_b[i*DW +: DW] = opb[i];
            req_op[i*3 +: 3]  = opc[i];
        end
    endtask

    // One full transaction starting from IDLE. bp = cycles of held backpressure,
    // bp_mask = valids raised while busy (must not be accepted).
    task automatic run_txn(input string nm, input logic [N-1:0] mask, input int bp,
                           input logic [N-1:0] bp_mask);
        int g;
        int g2;
        logic [31:0] er;
        logic        ee;
        @(negedge clk);
        drive_ops();
        req_valid = mask;
        #1;
        g = pick(mask, model_last);
        chk({nm, "_ready"}, 32'(req_ready), 32'(1) << g);
        model_last = g;
        ref_alu(opc[g], opa[g], opb[g], er, ee);
        @(negedge clk);
        req_valid = bp_mask;
        #1;
        chk({nm, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_exec_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({nm, "_id"}, 32'(rsp_id), 32'(g));
        chk({nm, "_result"}, rsp_result, er);
        chk({nm, "_err"}, 32'(rsp_err), 32'(ee));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({nm, "_hold_result"}, rsp_result, er);
            chk({nm, "_hold_id"}, 32'(rsp_id), 32'(g));
            chk({nm, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk({nm, "_done_valid"}, 32'(rsp_valid), 32'd0);
        if (bp_mask != 0) begin
            g2 = pick(bp_mask, model_last);
            chk({nm, "_next_grant"}, 32'(req_ready), 32'(1) << g2);
        end
        // Withdraw before the edge: legal, nothing captured.
        req_valid = '0;
    endtask

    initial begin
        int got;
        int g;
        logic [31:0] er;
        logic        ee;

        vecs[0]  = '{0, 32'd5,        32'd7,        3'b010, 32'd12,       1'b0};
        vecs[1]  = '{1, 32'hFFFFFFFF, 32'd1,        3'b010, 32'd0,        1'b0};
        vecs[2]  = '{2, 32'd0,        32'd1,        3'b110, 32'hFFFFFFFF, 1'b0};
        vecs[3]  = '{0, 32'h12345678, 32'h0001ABCD, 3'b011, 32'hABCD0000, 1'b0};
        vecs[4]  = '{1, 32'hFFFFFFFF, 32'd1,        3'b111, 32'd0,        1'b0};
        vecs[5]  = '{2, 32'd1,        32'hFFFFFFFF, 3'b111, 32'd1,        1'b0};
        vecs[6]  = '{0, 32'hF0F0FF00, 32'h0FF0F0F0, 3'b000, 32'h00F0F000, 1'b0};
        vecs[7]  = '{1, 32'hF0F0FF00, 32'h0FF0F0F0, 3'b001, 32'hFFF0FFF0, 1'b0};
        vecs[8]  = '{2, 32'd3,        32'd4,        3'b101, 32'd0,        1'b1};
        vecs[9]  = '{0, 32'd9,        32'd9,        3'b100, 32'd0,        1'b1};
        vecs[10] = '{1, 32'd10,       32'd3,        3'b110, 32'd7,        1'b0};

        for (int i = 0; i < int'(N); i++) begin
            opa[i] = '0; opb[i] = '0; opc[i] = '0;
        end

        // Reset values, with valids raised to show nothing is granted in reset.
        req_valid = '1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;

        // Directed table, one requester at a time.
        foreach (vecs[i]) begin
            opa[vecs[i].r] = vecs[i].a;
            opb[vecs[i].r] = vecs[i].b;
            opc[vecs[i].r] = vecs[i].op;
            run_txn($sformatf("vec%0d", i), 3'(1) << vecs[i].r, 0, '0);
            ref_alu(vecs[i].op, vecs[i].a, vecs[i].b, er, ee);
            chk($sformatf("vec%0d_table", i), rsp_result, vecs[i].res);
        end

        // Backpressure: hold 5 cycles with requester 2 waiting.
        opa[0] = 32'd100; opb[0] = 32'd23; opc[0] = 3'b010;
        run_txn("bp", 3'b001, 5, 3'b100);

        // Contention: requesters 0 and 1 valid continuously.
        opa[0] = 32'd1;  opb[0] = 32'd1; opc[0] = 3'b010;
        opa[1] = 32'd10; opb[1] = 32'd3; opc[1] = 3'b110;
        @(negedge clk);
        drive_ops();
        req_valid = 3'b011;
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                g = pick(3'b011, model_last);
                model_last = g;
                chk($sformatf("cont%0d_id", got), 32'(rsp_id), 32'(g));
                chk($sformatf("cont%0d_result", got), rsp_result, (g == 0) ? 32'd2 : 32'd7);
                got++;
            end
        end
        chk("cont_count", 32'(got), 32'd4);
        req_valid = '0;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);

        // Reset while in EXEC.
        opa[0] = 32'd4; opb[0] = 32'd4; opc[0] = 3'b010;
        drive_ops();
        req_valid = 3'b001;
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rst_exec_hold", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        model_last = N - 1;
        @(negedge clk);
        chk("rst_exec_no_rsp", 32'(rsp_valid), 32'd0);

        // Reset while in RESP: outputs clear immediately.
        opa[1] = 32'h55; opb[1] = 32'h0F; opc[1] = 3'b001;
        drive_ops();
        req_valid = 3'b010;
        #1;
        chk("rst_resp_ready", 32'(req_ready), 32'd2);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("rst_resp_pre", rsp_result, 32'h5F);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_resp_result", rsp_result, 32'd0);
        chk("rst_resp_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = N - 1;
        run_txn("post_rst", 3'b111, 0, '0);

        // Randomised: random valid sets, operands, ops and backpressure.
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < int'(N); j++) begin
                opa[j] = $urandom();
                opb[j] = ($urandom_range(0, 3) == 0) ? opa[j] : $urandom();
                opc[j] = 3'($urandom_range(0, 7));
            end
            run_txn($sformatf("rnd%0d", i), 3'($urandom_range(1, 7)),
                    int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
